fb_read_arbiter: RTL
====================

FB_READ_ARBITER -- requirements
Module: fb_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-002 The block SHALL have parameter DATA_W, default 12, pixel width (RGB444).
REQ-003 The block SHALL have parameter FB_DEPTH, default 76800, number of frame-buffer words (320x240).
REQ-004 The block SHALL have parameter RD_LAT, default 2, frame-buffer read latency in clk cycles, range 1..4.
REQ-005 The block SHALL have port clk, input, 1, VGA pixel clock (25 MHz); all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port vga_active, input, 1, scan-out active area; VGA owns the read port while high.
REQ-008 The block SHALL have port vga_addr, input, ADDR_W, scan-out read address.
REQ-009 The block SHALL have port fb_rdaddress, output, ADDR_W, address to frame-buffer read port.
REQ-010 The block SHALL have port fb_q, input, DATA_W, frame-buffer read data.
REQ-011 The block SHALL have port vga_q, output, DATA_W, scan-out pixel data.
REQ-012 The block SHALL have port hst_req, input, 1, secondary-reader burst request (level).
REQ-013 The block SHALL have ports hst_addr, input, ADDR_W, and hst_len, input, 8: burst start address and word count.
REQ-014 The block SHALL have port hst_ack, output, 1, one-cycle pulse on burst acceptance.
REQ-015 The block SHALL have ports hst_data, output, DATA_W, and hst_valid, output, 1: returned burst word and its qualifier.
REQ-016 The block SHALL have ports hst_busy, output, 1, burst in progress, and hst_done, output, 1, one-cycle pulse after the last word.

Function
REQ-017 fb_rdaddress SHALL equal vga_addr combinationally whenever vga_active=1, regardless of FSM state.
REQ-018 vga_q SHALL equal fb_q combinationally at all times; VGA read latency is exactly RD_LAT, unchanged by the block.
REQ-019 FSM states SHALL be IDLE, BURST, DRAIN; reset state IDLE.
REQ-020 IDLE: on hst_req=1 with hst_len!=0, latch hst_addr/hst_len into cur_addr/remaining, pulse hst_ack that cycle, go to BURST next cycle.
REQ-021 IDLE: hst_req=1 with hst_len=0 SHALL be ignored: no ack, no state change.
REQ-022 hst_req in BURST or DRAIN SHALL be ignored (no ack); requester holds or re-requests later.
REQ-023 BURST, cycle with vga_active=0: issue one read (fb_rdaddress=cur_addr), cur_addr increments, remaining decrements.
REQ-024 BURST, cycle with vga_active=1: no issue; cur_addr and remaining hold (VGA always wins, including the cycle vga_active rises).
REQ-025 cur_addr SHALL wrap from FB_DEPTH-1 to 0; addresses >= FB_DEPTH latched from hst_addr SHALL be reduced to 0.
REQ-026 When the issue making remaining=0 occurs, FSM SHALL go to DRAIN next cycle.
REQ-027 In IDLE/DRAIN with vga_active=0, fb_rdaddress SHALL be 0 (no host issue).
REQ-028 Each issue SHALL set a bit entering an RD_LAT-deep issue-tag shift register; hst_data<=fb_q and hst_valid<=1 registered when the tag exits, i.e. hst_valid high exactly RD_LAT+1 cycles after the issue cycle.
REQ-029 hst_valid count per burst SHALL equal the accepted hst_len; data order SHALL equal address order; no back-pressure exists.
REQ-030 DRAIN: when the tag register is empty and the last hst_valid has been output, pulse hst_done one cycle and return to IDLE the following cycle.
REQ-031 hst_busy SHALL be 1 in BURST and DRAIN, 0 in IDLE.
REQ-032 hst_ack SHALL be 0 on every cycle other than the acceptance cycle; a new burst is accepted no earlier than the cycle after hst_done.

Reset
REQ-033 reset=1 SHALL force IDLE, clear the tag register, cur_addr and remaining, and drive hst_ack, hst_valid, hst_done, hst_busy to 0 and hst_data to 0 on the next edge.
REQ-034 Reset mid-burst SHALL abort it: no hst_valid or hst_done for in-flight reads after reset deasserts.
REQ-035 vga_q and fb_rdaddress (vga_active=1 path) SHALL remain combinational pass-through during reset.

Verification
REQ-036 vga_active=0, hst_req hst_addr=100 hst_len=4 -> ack at t0; issues 100..103 at t1..t4; hst_valid at t1+RD_LAT+1..t4+RD_LAT+1 with fb model data; done one cycle after last valid.
REQ-037 Same burst with vga_active=1 on t2..t5 -> issues at t1,t6,t7,t8; fb_rdaddress=vga_addr t2..t5; 4 valids in order 100..103.
REQ-038 hst_addr=76798 hst_len=4 -> issued addresses 76798, 76799, 0, 1.
REQ-039 hst_len=0 request, and second request during BURST -> no hst_ack, no state change, first burst completes unaffected.
REQ-040 reset pulsed one cycle after 2nd issue of an 8-word burst -> hst_valid/hst_done stay 0 afterward; new 1-word burst accepted and completes correctly.
REQ-041 Continuous vga_active=1 over 1000 cycles with random vga_addr -> fb_rdaddress==vga_addr, vga_q==fb_q every cycle.

Source files
------------

// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: VGA scan-out owns the port while active,
// and a secondary reader drains bursts into the idle gaps with a tagged return path.
`timescale 1ns/1ps
module fb_read_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 12,
    parameter int FB_DEPTH = 76800,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_active,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] fb_rdaddress,
    input  logic [DATA_W-1:0] fb_q,
    output logic [DATA_W-1:0] vga_q,
    input  logic              hst_req,
    input  logic [ADDR_W-1:0] hst_addr,
    input  logic [7:0]        hst_len,
    output logic              hst_ack,
    output logic [DATA_W-1:0] hst_data,
    output logic              hst_valid,
    output logic              hst_busy,
    output logic              hst_done,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [7:0]          r_remaining;
    logic [RD_LAT-1:0]   r_tag;
    logic                r_valid;
    logic                r_done;
    logic [DATA_W-1:0]   r_data;

    logic                w_accept;
    logic                w_issue;
    logic                w_tag_exit;
    logic [ADDR_W-1:0]   w_start_addr;
    logic [ADDR_W-1:0]   w_next_addr;

    // Acceptance is suppressed during reset so the ack never announces a burst that reset discards.
    assign w_accept     = (r_state == IDLE) && hst_req && (hst_len != 8'd0) && !reset;
    assign w_issue      = (r_state == BURST) && !vga_active;
    assign w_tag_exit   = r_tag[RD_LAT-1];
    assign w_start_addr = ({1'b0, hst_addr} >= DEPTH_X) ? '0 : hst_addr;
    assign w_next_addr  = (r_cur_addr == LAST_ADDR) ? '0 : r_cur_addr + ADDR_W'(1);

    always_comb begin
        fb_rdaddress = '0;
        if (vga_active) begin
            fb_rdaddress = vga_addr;
        end else if (w_issue) begin
            fb_rdaddress = r_cur_addr;
        end
    end

    assign vga_q       = fb_q;
    assign hst_ack     = w_accept;
    assign hst_valid   = r_valid;
    assign hst_data    = r_data;
    assign hst_done    = r_done;
    assign hst_busy    = (r_state != IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_tag       <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_data      <= '0;
        end else begin
            // Tag bit follows each issued read through the RAM pipeline; its exit marks fb_q as ours.
            r_tag   <= (r_tag << 1) | RD_LAT'(w_issue);
            r_valid <= w_tag_exit;
            if (w_tag_exit) begin
                r_data <= fb_q;
            end
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cur_addr  <= w_start_addr;
                        r_remaining <= hst_len;
                        r_state     <= BURST;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        r_cur_addr  <= w_next_addr;
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Tags empty means the final word is on hst_valid now; done follows it.
                    if (r_done) begin
                        r_state <= IDLE;
                    end else if (r_tag == '0) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
